// File: rtl/ctrl_pipe_unit.sv
// Pipelined control unit: combinational decode, then E/M/W control registers with stall/flush and flag tracking.
// Build macro COND_EXEC_EN enables ARM-style conditional execution; without it, cond is ignored.
module ctrl_pipe_unit #(
  parameter int unsigned ALUCTL_W   = 4,
  parameter logic [3:0]  MEM_ALU_OP = 4'b0100
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          op,
  input  logic [5:0]          funct,
  input  logic [3:0]          cond,
  input  logic                valid_d,
  input  logic                stall_e,
  input  logic                flush_e,
  input  logic [3:0]          alu_flags,
  output logic [1:0]          imm_src_d,
  output logic [1:0]          reg_src_d,
  output logic [ALUCTL_W-1:0] alu_control_e,
  output logic                alu_src_e,
  output logic                mov_imm_e,
  output logic                dest_src_e,
  output logic                cond_pass_e,
  output logic                branch_taken_e,
  output logic                mem_write_m,
  output logic                reg_write_m,
  output logic                reg_write_w,
  output logic [1:0]          result_src_w,
  output logic                reg_data_src_w,
  output logic                pc_src_w,
  output logic [3:0]          flags_q
);

  localparam logic [ALUCTL_W-1:0] MEM_OP_EXT = ALUCTL_W'(MEM_ALU_OP);

  typedef struct packed {
    logic                reg_write;
    logic                mem_write;
    logic                mov_imm;
    logic                alu_src;
    logic                pc_src;
    logic                branch;
    logic                reg_data_src;
    logic                dest_src;
    logic [1:0]          flag_write;
    logic [1:0]          result_src;
    logic [ALUCTL_W-1:0] alu_control;
  } ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       pc_src;
    logic       reg_data_src;
    logic [1:0] result_src;
  } mem_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic       pc_src;
    logic       reg_data_src;
    logic [1:0] result_src;
  } wb_ctrl_t;

  ctrl_t     dec;
  ctrl_t     e_q, e_d;
  mem_ctrl_t m_q, m_d;
  wb_ctrl_t  w_q, w_d;
  logic      valid_e_q, valid_e_d;
  logic      valid_m_q, valid_m_d;
  logic      valid_w_q, valid_w_d;
  logic [3:0] flags_d;
  logic      pass_e;
  logic      flag_upd;

  always_comb begin : decode
    dec = '0;
    case (op)
      2'b00: begin
        dec.reg_write          = ~funct[5] | (funct == 6'b111010);
        dec.mov_imm            = funct[5];
        dec.alu_control[3:0]   = funct[4:1];
        dec.pc_src             = (funct == 6'b010010);
        dec.flag_write[1]      = funct[0];
        dec.flag_write[0]      = funct[0] & ((funct[4:1] == 4'd2) || (funct[4:1] == 4'd4) ||
                                             (funct[4:1] == 4'd10));
      end
      2'b01: begin
        dec.mem_write   = ~funct[0];
        dec.reg_write   = funct[0];
        dec.alu_src     = 1'b1;
        dec.alu_control = MEM_OP_EXT;
      end
      2'b10: begin
        dec.branch       = funct[5];
        dec.reg_write    = funct[4];
        dec.reg_data_src = funct[4];
        dec.dest_src     = 1'b1;
        dec.alu_src      = 1'b1;
        dec.alu_control  = MEM_OP_EXT;
      end
      default: dec = '0;
    endcase
    dec.result_src = {dec.pc_src, dec.pc_src | (op == 2'b01)};
  end

  assign imm_src_d = op;
  assign reg_src_d = {op == 2'b10, op == 2'b01};

`ifdef COND_EXEC_EN
  logic [3:0] cond_e_q, cond_e_d;

  // Pairs of codes share a base test; the odd code of each pair is its inverse.
  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n_f, z_f, c_f, v_f, base;
    {n_f, z_f, c_f, v_f} = f;
    case (c[3:1])
      3'b000:  base = z_f;
      3'b001:  base = c_f;
      3'b010:  base = n_f;
      3'b011:  base = v_f;
      3'b100:  base = c_f & ~z_f;
      3'b101:  base = (n_f == v_f);
      3'b110:  base = ~z_f & (n_f == v_f);
      default: base = 1'b1;
    endcase
    return (c[3:1] == 3'b111) ? 1'b1 : (base ^ c[0]);
  endfunction

  always_comb begin : cond_next
    cond_e_d = cond_e_q;
    if (flush_e) begin
      cond_e_d = '0;
    end else if (!stall_e) begin
      cond_e_d = cond;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cond_e_q <= '0;
    end else begin
      cond_e_q <= cond_e_d;
    end
  end

  assign pass_e = valid_e_q & cond_holds(cond_e_q, flags_q);
`else
  logic cond_unused;
  assign cond_unused = ^cond;
  assign pass_e      = valid_e_q;
`endif

  always_comb begin : e_next
    e_d       = e_q;
    valid_e_d = valid_e_q;
    if (flush_e) begin
      e_d       = '0;
      valid_e_d = 1'b0;
    end else if (!stall_e) begin
      e_d       = valid_d ? dec : '0;
      valid_e_d = valid_d;
    end
  end

  // A stalled E slot hands M a bubble; a failing instruction still advances, minus its side effects.
  always_comb begin : m_next
    m_d       = '0;
    valid_m_d = 1'b0;
    if (!stall_e) begin
      valid_m_d        = valid_e_q;
      m_d.reg_write    = e_q.reg_write & pass_e;
      m_d.mem_write    = e_q.mem_write & pass_e;
      m_d.pc_src       = e_q.pc_src & pass_e;
      m_d.reg_data_src = e_q.reg_data_src;
      m_d.result_src   = e_q.result_src;
    end
  end

  always_comb begin : w_next
    valid_w_d        = valid_m_q;
    w_d.reg_write    = m_q.reg_write;
    w_d.pc_src       = m_q.pc_src;
    w_d.reg_data_src = m_q.reg_data_src;
    w_d.result_src   = m_q.result_src;
  end

  assign flag_upd = pass_e & ~stall_e;

  // flag_write[1] covers {N,Z} (bits 3:2), flag_write[0] covers {C,V} (bits 1:0).
  for (genvar gi = 0; gi < 4; gi++) begin : g_flag
    assign flags_d[gi] = (flag_upd && e_q.flag_write[gi/2]) ? alu_flags[gi] : flags_q[gi];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q       <= '0;
      m_q       <= '0;
      w_q       <= '0;
      valid_e_q <= 1'b0;
      valid_m_q <= 1'b0;
      valid_w_q <= 1'b0;
      flags_q   <= '0;
    end else begin
      e_q       <= e_d;
      m_q       <= m_d;
      w_q       <= w_d;
      valid_e_q <= valid_e_d;
      valid_m_q <= valid_m_d;
      valid_w_q <= valid_w_d;
      flags_q   <= flags_d;
    end
  end

  assign alu_control_e  = valid_e_q ? e_q.alu_control : '0;
  assign alu_src_e      = valid_e_q & e_q.alu_src;
  assign mov_imm_e      = valid_e_q & e_q.mov_imm;
  assign dest_src_e     = valid_e_q & e_q.dest_src;
  assign cond_pass_e    = pass_e;
  assign branch_taken_e = valid_e_q & e_q.branch & pass_e;

  assign mem_write_m    = valid_m_q & m_q.mem_write;
  assign reg_write_m    = valid_m_q & m_q.reg_write;

  assign reg_write_w    = valid_w_q & w_q.reg_write;
  assign result_src_w   = valid_w_q ? w_q.result_src : 2'b00;
  assign reg_data_src_w = valid_w_q & w_q.reg_data_src;
  assign pc_src_w       = valid_w_q & w_q.pc_src;

endmodule
